// File: rtl/rng_pkg.sv
// Shared definitions for the RNG seed collector.
// Holds the collector FSM state type and the default seed width and
// repetition-count limit used by rng_seed_collector and rng_rep_test.
package rng_pkg;

    localparam int unsigned RNG_WIDTH     = 32;
    localparam int unsigned RNG_REP_LIMIT = 8;

    // FIRST/SECOND are the two halves of a debiasing pair. The direct build
    // collects from FIRST only.
    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        SECOND,
        FULL,
        FAIL
    } rng_state_e;

endpackage

// File: rtl/rng_rep_test.sv
// Repetition-count health test on the raw entropy stream.
// Counts how long the current run of identical samples is. trip is
// combinational so the owner can react at the same edge that the run
// reaches REP_LIMIT.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   sample         : raw noise bit
//   enable         : sample is valid this cycle
//   clear          : forget the current run
//   trip           : this sample makes the run REP_LIMIT long
module rng_rep_test
    import rng_pkg::*;
#(
    parameter int unsigned REP_LIMIT = RNG_REP_LIMIT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sample,
    input  logic enable,
    input  logic clear,
    output logic trip
);

    logic [7:0] run;
    logic [7:0] run_nxt;
    logic       last;

    // A run of 0 means "no previous sample", so the next one always starts at 1.
    always_comb begin
        run_nxt = 8'd1;
        if (run != 8'd0 && sample == last) begin
            run_nxt = run + 8'd1;
        end
    end

    assign trip = enable && (run_nxt == 8'(REP_LIMIT));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            run  <= 8'd0;
            last <= 1'b0;
        end else if (clear) begin
            run  <= 8'd0;
        end else if (enable) begin
            run  <= run_nxt;
            last <= sample;
        end
    end

endmodule

// File: rtl/rng_seed_collector.sv
// Collects raw entropy bits into a WIDTH-bit seed word for an LFSR loader.
// Build option RNG_SEED_DEBIAS_EN: when defined, raw samples are
// von Neumann debiased in pairs. When undefined, every enabled sample is
// shifted in directly. A repetition-count health test guards the raw
// stream in both builds.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   en_i           : collection enable
//   noise_i        : raw entropy bit (already synchronized)
//   seed_valid_o   : seed word presented; held until seed_ready_i
//   seed_ready_i   : consumer accepts the word
//   seed_o         : collected word, newest bit in the LSB
//   hlth_fail_o    : sticky health-test failure
//   clr_fail_i     : clears the failure and returns to IDLE
module rng_seed_collector
    import rng_pkg::*;
#(
    parameter int unsigned WIDTH     = RNG_WIDTH,
    parameter int unsigned REP_LIMIT = RNG_REP_LIMIT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             noise_i,
    output logic             seed_valid_o,
    input  logic             seed_ready_i,
    output logic [WIDTH-1:0] seed_o,
    output logic             hlth_fail_o,
    input  logic             clr_fail_i
);

    localparam int CW = $clog2(WIDTH + 1);

    rng_state_e       state, state_d;
    logic [WIDTH-1:0] word, word_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             pair, pair_d;
    logic             take, bit_in;
    logic             trip, rep_en, rep_clr;

    // The health test only sees samples that the collector actually consumes.
    // It is paused in FULL and FAIL.
    assign rep_en  = en_i && (state == FIRST || state == SECOND);
    assign rep_clr = (state == FAIL) && clr_fail_i;

    rng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .sample (noise_i),
        .enable (rep_en),
        .clear  (rep_clr),
        .trip   (trip)
    );

    always_comb begin
        state_d = state;
        word_d  = word;
        cnt_d   = cnt;
        pair_d  = pair;
        take    = 1'b0;
        bit_in  = noise_i;
        case (state)
            IDLE: begin
                if (en_i) state_d = FIRST;
            end
            FIRST, SECOND: begin
                if (!en_i || trip) begin
                    // Drop the partial word whether we stop or fail.
                    state_d = trip ? FAIL : IDLE;
                    word_d  = '0;
                    cnt_d   = '0;
                    pair_d  = 1'b0;
                end else if (state == FIRST) begin
`ifdef RNG_SEED_DEBIAS_EN
                    pair_d  = noise_i;
                    state_d = SECOND;
`else
                    take    = 1'b1;
`endif
                end else begin
                    // Unequal pair keeps its first bit. Equal pair is discarded.
                    state_d = FIRST;
                    pair_d  = 1'b0;
                    if (noise_i != pair) begin
                        take   = 1'b1;
                        bit_in = pair;
                    end
                end
            end
            FULL: begin
                if (seed_ready_i) begin
                    word_d  = '0;
                    cnt_d   = '0;
                    state_d = en_i ? FIRST : IDLE;
                end
            end
            FAIL: begin
                if (clr_fail_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            word_d = {word[WIDTH-2:0], bit_in};
            cnt_d  = cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state_d = FULL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            word  <= '0;
            cnt   <= '0;
            pair  <= 1'b0;
        end else begin
            state <= state_d;
            word  <= word_d;
            cnt   <= cnt_d;
            pair  <= pair_d;
        end
    end

    assign seed_o       = word;
    assign seed_valid_o = (state == FULL);
    assign hlth_fail_o  = (state == FAIL);

endmodule

// File: tb/tb_rng_seed_collector.sv
// Directed bench for rng_seed_collector (WIDTH=32, REP_LIMIT=8).
// feed_bit() sends one accepted bit in either build: a single raw sample,
// or a (b, ~b) pair when RNG_SEED_DEBIAS_EN is defined.
module tb_rng_seed_collector;
    import rng_pkg::*;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_n_i, en_i, noise_i, seed_ready_i, clr_fail_i;
    logic         seed_valid_o, hlth_fail_o;
    logic [W-1:0] seed_o;
    logic [31:0]  w;
    logic [31:0]  held;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    rng_seed_collector #(.WIDTH(W), .REP_LIMIT(8)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .noise_i     (noise_i),
        .seed_valid_o(seed_valid_o),
        .seed_ready_i(seed_ready_i),
        .seed_o      (seed_o),
        .hlth_fail_o (hlth_fail_o),
        .clr_fail_i  (clr_fail_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input logic n);
        noise_i = n;
        tick();
    endtask

    task automatic feed_bit(input logic b);
`ifdef RNG_SEED_DEBIAS_EN
        step(b);
        step(~b);
`else
        step(b);
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0; en_i = 1'b0; noise_i = 1'b0;
        seed_ready_i = 1'b0; clr_fail_i = 1'b0;
        tick();
        tick();
        chk("rst_seed",  seed_o, 32'h0);
        chk("rst_valid", 32'(seed_valid_o), 32'd0);
        chk("rst_hlth",  32'(hlth_fail_o), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // Word 0xA5A5A5A5, MSB first. valid appears only after the last bit.
        rst_n_i = 1'b1;
        en_i = 1'b1;
        tick();
        w = 32'hA5A5A5A5;
        for (int i = 31; i >= 1; i--) feed_bit(w[i]);
        chk("a5_early_valid", 32'(seed_valid_o), 32'd0);
        feed_bit(w[0]);
        chk("a5_valid", 32'(seed_valid_o), 32'd1);
        chk("a5_seed",  seed_o, 32'hA5A5A5A5);

        // Backpressure: noise and en toggle while the word is held.
        held = 32'hA5A5A5A5;
        for (int i = 0; i < 10; i++) begin
            noise_i = i[0];
            en_i = (i % 3) != 0;
            tick();
            chk("bp_seed",  seed_o, held);
            chk("bp_valid", 32'(seed_valid_o), 32'd1);
        end
        en_i = 1'b1;
        seed_ready_i = 1'b1;
        tick();
        seed_ready_i = 1'b0;
        chk("pop_valid", 32'(seed_valid_o), 32'd0);
        chk("pop_cnt",   32'(dut.cnt), 32'd0);
        chk("pop_seed",  seed_o, 32'h0);
        chk("pop_state", 32'(dut.state), 32'(FIRST));

`ifdef RNG_SEED_DEBIAS_EN
        // 32 pairs (1,0). The 64th raw sample completes the word.
        for (int i = 0; i < 31; i++) feed_bit(1'b1);
        chk("ff_early_valid", 32'(seed_valid_o), 32'd0);
        feed_bit(1'b1);
        chk("ff_valid", 32'(seed_valid_o), 32'd1);
        chk("ff_seed",  seed_o, 32'hFFFFFFFF);
        seed_ready_i = 1'b1;
        tick();
        seed_ready_i = 1'b0;

        // Equal pairs are all discarded.
        for (int i = 0; i < 20; i++) begin
            step(1'b0); step(1'b0); step(1'b1); step(1'b1);
        end
        chk("disc_cnt",   32'(dut.cnt), 32'd0);
        chk("disc_valid", 32'(seed_valid_o), 32'd0);
        chk("disc_hlth",  32'(hlth_fail_o), 32'd0);
`endif

        // Health test: a 0 starts a fresh run, then 8 ones trip on the 8th.
        step(1'b0);
        for (int i = 0; i < 7; i++) step(1'b1);
        chk("hlth_pre", 32'(hlth_fail_o), 32'd0);
        step(1'b1);
        chk("hlth_trip",  32'(hlth_fail_o), 32'd1);
        chk("hlth_state", 32'(dut.state), 32'(FAIL));
        chk("hlth_valid", 32'(seed_valid_o), 32'd0);
        step(1'b0);
        step(1'b1);
        chk("hlth_sticky", 32'(hlth_fail_o), 32'd1);
        clr_fail_i = 1'b1;
        en_i = 1'b0;
        tick();
        clr_fail_i = 1'b0;
        chk("clr_hlth",  32'(hlth_fail_o), 32'd0);
        chk("clr_state", 32'(dut.state), 32'(IDLE));

        // Reset in the middle of a word, then a full new word is needed.
        en_i = 1'b1;
        tick();
        w = 32'h0000A5A5;
        for (int i = 15; i >= 0; i--) feed_bit(w[i]);
        chk("mid_cnt", 32'(dut.cnt), 32'd16);
        rst_n_i = 1'b0;
        tick();
        chk("mrst_seed",  seed_o, 32'h0);
        chk("mrst_valid", 32'(seed_valid_o), 32'd0);
        chk("mrst_hlth",  32'(hlth_fail_o), 32'd0);
        chk("mrst_cnt",   32'(dut.cnt), 32'd0);
        chk("mrst_state", 32'(dut.state), 32'(IDLE));
        rst_n_i = 1'b1;
        tick();
        w = 32'h3C3C3C3C;
        for (int i = 31; i >= 1; i--) feed_bit(w[i]);
        chk("post_early_valid", 32'(seed_valid_o), 32'd0);
        feed_bit(w[0]);
        chk("post_valid", 32'(seed_valid_o), 32'd1);
        chk("post_seed",  seed_o, 32'h3C3C3C3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rng_seed_collector.md
RNG_SEED_COLLECTOR -- requirements
Module: rng_seed_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning seed word width in bits.
REQ-002 SHALL have parameter REP_LIMIT, default 8, meaning the raw-sample run length that trips the health test (range 2..255).
REQ-003 SHALL have port clk_i, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port en_i, input, 1, collection enable.
REQ-006 SHALL have port noise_i, input, 1, raw entropy bit, already synchronized to clk_i; sampled every enabled cycle.
REQ-007 SHALL have port seed_valid_o, output, 1, seed word available.
REQ-008 SHALL have port seed_ready_i, input, 1, consumer (LFSR seed loader) accepts the word.
REQ-009 SHALL have port seed_o, output, WIDTH, collected seed word.
REQ-010 SHALL have port hlth_fail_o, output, 1, sticky health-test failure.
REQ-011 SHALL have port clr_fail_i, input, 1, clears the failure and resumes collection.

Function
REQ-012 SHALL implement FSM states IDLE, FIRST (await first bit of pair), SECOND (await second bit), FULL (word presented), FAIL.
REQ-013 SHALL move IDLE->FIRST on en_i=1; en_i=0 in FIRST/SECOND -> IDLE, discarding the partial word, bit count and held pair bit.
REQ-014 SHALL, per pair (a,b) under debiasing, accept bit a when a!=b and discard the pair when a==b (von Neumann).
REQ-015 SHALL shift each accepted bit into the LSB: word <= {word[WIDTH-2:0], bit}; bit counter 0..WIDTH.
REQ-016 SHALL enter FULL and assert seed_valid_o at the clock edge that accepts bit WIDTH (registered, 1-cycle latency from the last sample).
REQ-017 SHALL, in FULL, hold seed_o and seed_valid_o stable, ignore noise_i, pause the health test, and ignore en_i (a presented word is never withdrawn).
REQ-018 SHALL, on seed_valid_o && seed_ready_i, deassert seed_valid_o at the next edge, clear word and counter to 0, and go to FIRST if en_i=1, else IDLE.
REQ-019 SHALL run a repetition-count test on every enabled raw sample in FIRST/SECOND: run counter starts at 1 and increments on a repeated value, resets to 1 on a change.
REQ-020 SHALL, when the run counter reaches REP_LIMIT, set hlth_fail_o at that edge, discard the partial word, and enter FAIL.
REQ-021 SHALL, in FAIL, keep seed_valid_o=0, ignore noise_i, and on clr_fail_i=1 clear hlth_fail_o, reset the run counter, and go to IDLE next edge.
REQ-022 SHALL give a failure detected in the same cycle as clr_fail_i priority; clr_fail_i outside FAIL has no effect.

Reset
REQ-023 SHALL, with rst_n_i=0 at a clock edge, set state IDLE, seed_o=0, seed_valid_o=0, hlth_fail_o=0, and the bit counter, run counter and held pair bit to 0, including mid-word and in FULL/FAIL.

Configuration
REQ-024 SHALL honour macro RNG_SEED_DEBIAS_EN: defined -> von Neumann pairing per REQ-014; undefined -> every enabled raw sample is accepted directly, SECOND is unused, and a word completes after exactly WIDTH enabled samples; the health test is identical in both builds.

Structure
REQ-025 SHALL take the FSM state typedef and the default WIDTH/REP_LIMIT constants from the shared package rng_pkg.
REQ-026 SHALL place the repetition-count test in sub-module rng_rep_test (inputs sample, enable, clear; output trip).

Verification
REQ-027 SHALL cover debias: en_i=1, pairs (1,0) x32 -> seed_o=0xFFFFFFFF, seed_valid_o rising the cycle after the 64th sample.
REQ-028 SHALL cover discard: pattern 0,0,1,1 repeated 20 times -> bit counter stays 0, seed_valid_o=0, hlth_fail_o=0.
REQ-029 SHALL cover backpressure: word full, seed_ready_i=0 for 10 cycles with toggling noise_i and en_i -> seed_o stable, valid held; seed_ready_i=1 for 1 cycle -> valid=0 next cycle and counter=0.
REQ-030 SHALL cover health: 8 consecutive noise_i=1 samples -> hlth_fail_o=1 at the 8th-sample edge, FAIL entered; clr_fail_i pulse -> hlth_fail_o=0, IDLE.
REQ-031 SHALL cover reset: rst_n_i=0 for one cycle after 16 accepted bits -> all outputs 0; a fresh full word is then required before valid.
REQ-032 SHALL cover the no-macro build: 32 samples MSB-first of 0xA5A5A5A5 -> seed_o=0xA5A5A5A5, valid the cycle after the 32nd sample.
